memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
Memory (MEM) stage of the 16-bit MISC-V pipeline. It contains a word-addressed data memory that is read and written using the ALU result as the address. It also holds the MEM/WB pipeline register, which forwards the control bits, ALU result and destination register, plus the registered memory read data, to the write-back stage.

Parameters:
ADDR_WIDTH, 10, number of data-memory address bits; depth = 2^ADDR_WIDTH 16-bit words.
DATA_WIDTH, 16, word width; fixed at 16 for this design.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
IRegWrite  input  1  register-file write enable from EX/MEM.
IRegStore  input  1  write-back select: load data vs ALU result.
MemWrite  input  1  data-memory write enable.
MemRead  input  1  data-memory read enable.
IALUResult  input  16  ALU result; memory address (low ADDR_WIDTH bits) and pass-through value.
thirdArg  input  16  store data (rs2/third operand).
rdMem  input  3  destination register index.
ORegWrite  output  1  registered IRegWrite.
ORegStore  output  1  registered IRegStore.
OALUResult  output  16  registered IALUResult.
StoreMem  output  16  registered memory read data.
rdWB  output  3  registered rdMem.

Behaviour:
- One clock, rising edge. Reset is synchronous and active-high. All outputs are registers, so there are no combinational paths from inputs to outputs.
- Reset: on any rising edge with reset=1, all five outputs become 0 (ORegWrite=0, ORegStore=0, OALUResult=16'h0000, StoreMem=16'h0000, rdWB=3'b000).
  - Memory writes are suppressed while reset=1.
  - Reset does not clear memory contents.
  - Memory initialises to all zeros at time 0.
- Normal edge (reset=0):
  - ORegWrite<=IRegWrite, ORegStore<=IRegStore, OALUResult<=IALUResult, rdWB<=rdMem. Latency is 1 cycle with no stall or enable.
- Address: addr = IALUResult[ADDR_WIDTH-1:0]. Memory is word addressed. Upper address bits are ignored, so addresses alias and wrap modulo 2^ADDR_WIDTH.
- Write: if MemWrite=1, mem[addr] <= thirdArg on the edge.
- Read: if MemRead=1, StoreMem <= mem[addr] on the same edge.
  - If MemWrite=1 in the same cycle, the read is write-first: StoreMem <= thirdArg, the new data.
- If MemRead=0, StoreMem <= 0, regardless of MemWrite.
- MemWrite=1 with MemRead=0: the memory is updated and StoreMem=0.
- Reset asserted mid-operation: the next edge zeroes the outputs and drops any pending write. Operation resumes on the first edge after reset deasserts.
- No handshake; inputs are sampled every cycle.

Test Plan:
1. Reset: reset=1, IRegWrite=1, IRegStore=1, MemRead=1, MemWrite=0, IALUResult=16'h0004, thirdArg=16'hAAAA, rdMem=3'b101; one edge -> all outputs 0.
2. Write-first pass-through: reset=0, MemWrite=1, MemRead=1, other inputs as in test 1; one edge -> ORegWrite=1, ORegStore=1, OALUResult=16'h0004, StoreMem=16'hAAAA, rdWB=3'b101.
3. Read-back: after test 2, MemWrite=0, MemRead=1, IALUResult=16'h0004, thirdArg=16'h5555 -> StoreMem=16'hAAAA, and mem[4] is unchanged.
4. Read disabled: MemRead=0, MemWrite=1, IALUResult=16'h0010, thirdArg=16'h1234 -> StoreMem=0. The next cycle, with MemRead=1 at address 16'h0010, gives StoreMem=16'h1234.
5. Address wrap with ADDR_WIDTH=10: write 16'hBEEF at IALUResult=16'h0405, then read IALUResult=16'h0005 -> StoreMem=16'hBEEF.
6. Reset mid-operation: reset=1 together with MemWrite=1, IALUResult=16'h0020, thirdArg=16'hCAFE -> outputs 0. Then reset=0 and read address 16'h0020 -> StoreMem=16'h0000, confirming the write was suppressed.

Source files
------------

// File: rtl/memory_stage.sv
// MEM stage of the 16-bit MISC-V pipeline: a word-addressed data memory plus the
// MEM/WB pipeline register that feeds the write-back stage.
module memory_stage #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  IRegWrite,
  input  logic                  IRegStore,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] IALUResult,
  input  logic [DATA_WIDTH-1:0] thirdArg,
  input  logic [2:0]            rdMem,
  output logic                  ORegWrite,
  output logic                  ORegStore,
  output logic [DATA_WIDTH-1:0] OALUResult,
  output logic [DATA_WIDTH-1:0] StoreMem,
  output logic [2:0]            rdWB
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Contents start at zero and are deliberately untouched by reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic [ADDR_WIDTH-1:0] addr;
  logic                  mem_we;

  logic                  reg_write_d, reg_write_q;
  logic                  reg_store_d, reg_store_q;
  logic [DATA_WIDTH-1:0] alu_result_d, alu_result_q;
  logic [DATA_WIDTH-1:0] store_mem_d, store_mem_q;
  logic [2:0]            rd_wb_d, rd_wb_q;

  always_comb begin
    addr         = IALUResult[ADDR_WIDTH-1:0];
    mem_we       = MemWrite && !reset;
    reg_write_d  = IRegWrite;
    reg_store_d  = IRegStore;
    alu_result_d = IALUResult;
    rd_wb_d      = rdMem;
    store_mem_d  = '0;
    // Write-first: a same-cycle store bypasses the array so the load sees new data.
    if (MemRead) begin
      store_mem_d = MemWrite ? thirdArg : mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr] <= thirdArg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      reg_store_q  <= 1'b0;
      alu_result_q <= '0;
      store_mem_q  <= '0;
      rd_wb_q      <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      reg_store_q  <= reg_store_d;
      alu_result_q <= alu_result_d;
      store_mem_q  <= store_mem_d;
      rd_wb_q      <= rd_wb_d;
    end
  end

  assign ORegWrite  = reg_write_q;
  assign ORegStore  = reg_store_q;
  assign OALUResult = alu_result_q;
  assign StoreMem   = store_mem_q;
  assign rdWB       = rd_wb_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage with hand-computed expectations.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        IRegWrite, IRegStore, MemWrite, MemRead;
  logic [15:0] IALUResult, thirdArg;
  logic [2:0]  rdMem;
  logic        ORegWrite, ORegStore;
  logic [15:0] OALUResult, StoreMem;
  logic [2:0]  rdWB;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  memory_stage #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .IRegWrite(IRegWrite), .IRegStore(IRegStore),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .IALUResult(IALUResult), .thirdArg(thirdArg), .rdMem(rdMem),
    .ORegWrite(ORegWrite), .ORegStore(ORegStore),
    .OALUResult(OALUResult), .StoreMem(StoreMem), .rdWB(rdWB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic rst, input logic rw, input logic rs, input logic mw,
                       input logic mr, input logic [15:0] alu, input logic [15:0] ta,
                       input logic [2:0] rd);
    @(negedge clk);
    reset = rst; IRegWrite = rw; IRegStore = rs; MemWrite = mw; MemRead = mr;
    IALUResult = alu; thirdArg = ta; rdMem = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic rw, input logic rs,
                           input logic [15:0] alu, input logic [15:0] sm, input logic [2:0] rd);
    check({tag, ".ORegWrite"},  {15'b0, ORegWrite}, {15'b0, rw});
    check({tag, ".ORegStore"},  {15'b0, ORegStore}, {15'b0, rs});
    check({tag, ".OALUResult"}, OALUResult, alu);
    check({tag, ".StoreMem"},   StoreMem, sm);
    check({tag, ".rdWB"},       {13'b0, rdWB}, {13'b0, rd});
  endtask

  initial begin
    reset = 1'b1; IRegWrite = 1'b0; IRegStore = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    IALUResult = '0; thirdArg = '0; rdMem = '0;

    // 1: reset zeroes all outputs even with active inputs
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0004, 16'hAAAA, 3'b101);
    check_all("reset", 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000);

    // 2: write-first pass-through
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0004, 16'hAAAA, 3'b101);
    check_all("wr_first", 1'b1, 1'b1, 16'h0004, 16'hAAAA, 3'b101);

    // 3: read-back, store data ignored when MemWrite=0
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0004, 16'h5555, 3'b010);
    check_all("readback", 1'b0, 1'b1, 16'h0004, 16'hAAAA, 3'b010);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h0000, 3'b011);
    check("mem4_unchanged", StoreMem, 16'hAAAA);

    // 4: read disabled while writing gives zero, data still lands
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h1234, 3'b001);
    check("rd_disabled", StoreMem, 16'h0000);
    check("rd_disabled.alu", OALUResult, 16'h0010);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 3'b001);
    check("rd_after_write", StoreMem, 16'h1234);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 16'hFFFF, 3'b000);
    check("rd_off_zero", StoreMem, 16'h0000);

    // 5: address aliasing modulo 1024
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0405, 16'hBEEF, 3'b000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000, 3'b000);
    check("wrap_low", StoreMem, 16'hBEEF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFC05, 16'h0000, 3'b000);
    check("wrap_high", StoreMem, 16'hBEEF);
    check("wrap_high.alu", OALUResult, 16'hFC05);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0006, 16'h0000, 3'b000);
    check("neighbour_zero", StoreMem, 16'h0000);

    // 6: reset mid-operation drops the write
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 3'b111);
    check_all("pre_reset", 1'b1, 1'b1, 16'h0010, 16'h1234, 3'b111);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 16'hCAFE, 3'b110);
    check_all("mid_reset", 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 3'b100);
    check_all("post_reset", 1'b1, 1'b0, 16'h0020, 16'h0000, 3'b100);

    // reset does not clear memory contents
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h0000, 3'b000);
    check("mem_survives_reset", StoreMem, 16'hAAAA);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
